// File: rtl/case_6_div_pkg.sv
// Shared widths, FSM encoding and constants for the case_6 signed divider.
// Imported by the divider top level and its restoring-step cell.
package case_6_div_pkg;

    localparam int DIV_N = 13;
    localparam int DIV_D = 7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    localparam logic [DIV_N-1:0] DIV0_Q = 13'h1FFF;

endpackage

// File: rtl/case_6_sdiv_13s_7s_13_seq_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor
// magnitude when it fits, and report the resulting quotient bit.
module case_6_sdiv_13s_7s_13_seq_step
    import case_6_div_pkg::*;
(
    input  logic [DIV_D:0]   part,
    input  logic             bit_in,
    input  logic [DIV_D-1:0] dmag,
    output logic [DIV_D:0]   part_nx,
    output logic             qbit
);

    logic [DIV_D+1:0] trial;
    logic [DIV_D+1:0] diff;

    assign trial = {part, bit_in};
    assign diff  = trial - {2'b00, dmag};

    // No borrow out of the subtraction means trial >= dmag.
    assign qbit    = ~diff[DIV_D+1];
    assign part_nx = qbit ? diff[DIV_D:0] : trial[DIV_D:0];

endmodule

// File: rtl/case_6_sdiv_13s_7s_13_seq.sv
// Sequential 13s/7s signed divider, radix-2 restoring, C truncating semantics.
// Valid/ready on both sides; one quotient bit per enabled cycle.
module case_6_sdiv_13s_7s_13_seq
    import case_6_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIV_N,
    parameter int din1_WIDTH = DIV_D,
    parameter int dout_WIDTH = DIV_N,
    parameter int rem_WIDTH  = DIV_D
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [rem_WIDTH-1:0]  rem,
    output logic                  div0
);

    div_state_t       state;
    div_state_t       nxt;
    logic [3:0]       cnt;
    logic [DIV_N-1:0] acc;
    logic [DIV_D:0]   part;
    logic [DIV_D-1:0] dmag;
    logic             sq;
    logic             sr;
    logic             z;
    logic [DIV_D:0]   part_nx;
    logic             qbit;

    case_6_sdiv_13s_7s_13_seq_step u_step (
        .part    (part),
        .bit_in  (acc[DIV_N-1]),
        .dmag    (dmag),
        .part_nx (part_nx),
        .qbit    (qbit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (ce && in_valid)        nxt = CALC;
            CALC: if (ce && cnt == 4'd0)     nxt = FIX;
            FIX:  if (ce)                    nxt = DONE;
            DONE: if (ce && out_ready)       nxt = IDLE;
            default:                         nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // acc holds |dividend| and fills with quotient bits as it shifts left.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt  <= '0;
            acc  <= '0;
            part <= '0;
            dmag <= '0;
            sq   <= 1'b0;
            sr   <= 1'b0;
            z    <= 1'b0;
            dout <= '0;
            rem  <= '0;
            div0 <= 1'b0;
        end else if (ce) begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc  <= din0[DIV_N-1] ? -din0 : din0;
                        dmag <= din1[DIV_D-1] ? -din1 : din1;
                        sq   <= din0[DIV_N-1] ^ din1[DIV_D-1];
                        sr   <= din0[DIV_N-1];
                        z    <= (din1 == '0);
                        part <= '0;
                        cnt  <= 4'd12;
                    end
                end
                CALC: begin
                    part <= part_nx;
                    acc  <= {acc[DIV_N-2:0], qbit};
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                FIX: begin
                    if (z) begin
                        dout <= DIV0_Q;
                        rem  <= '0;
                        div0 <= 1'b1;
                    end else begin
                        dout <= sq ? -acc : acc;
                        rem  <= sr ? -part[DIV_D-1:0] : part[DIV_D-1:0];
                        div0 <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case_6_sdiv_13s_7s_13_seq.sv
// Self-checking bench for the case_6 sequential signed divider.
// Expected results come from integer C-style division in the bench.
module tb_case_6_sdiv_13s_7s_13_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] din0 = '0;
    logic [6:0]  din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] dout;
    logic [6:0]  rem;
    logic        div0;

    int checks = 0;
    int passed = 0;

    case_6_sdiv_13s_7s_13_seq #(.ID(1)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .rem       (rem),
        .div0      (div0)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic void model(input logic [12:0] a, input logic [6:0] b,
                                  output logic [12:0] q, output logic [6:0] r,
                                  output logic z);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q = 13'h1FFF;
            r = '0;
            z = 1'b1;
        end else begin
            q = 13'(ia / ib);
            r = 7'(ia % ib);
            z = 1'b0;
        end
    endfunction

    task automatic issue(input logic [12:0] a, input logic [6:0] b);
        @(negedge ap_clk);
        din0 = a;
        din1 = b;
        in_valid = 1'b1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        din0 = 13'($urandom);
        din1 = 7'($urandom);
    endtask

    task automatic wait_valid(output int lat, output bit busy);
        lat = 0;
        busy = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy = 1'b0;
            @(posedge ap_clk);
            lat++;
            @(negedge ap_clk);
        end
        if (in_ready) busy = 1'b0;
        if (!out_valid) lat = -1;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [12:0] a, input logic [6:0] b,
                          output logic [12:0] q, output logic [6:0] r,
                          output logic z, output int lat, output bit busy);
        issue(a, b);
        wait_valid(lat, busy);
        q = dout;
        r = rem;
        z = div0;
        retire();
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else passed++;
        checks++;
        if ({dout, rem, div0} !== 21'd0)
            $display("FAIL reset_outputs got %h/%h/%b want 0/0/0", dout, rem, div0);
        else passed++;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [12:0] q;
        logic [6:0]  r;
        logic        z;
        int          lat;
        bit          busy;
        run_op(13'd100, 7'd7, q, r, z, lat, busy);
        checks++;
        if (lat !== 14) $display("FAIL basic_latency got %0d want 14", lat);
        else passed++;
        checks++;
        if (busy !== 1'b1) $display("FAIL basic_in_ready_low got %b want 1", busy);
        else passed++;
        checks++;
        if ({q, r, z} !== {13'd14, 7'd2, 1'b0})
            $display("FAIL basic_result got q=%0d r=%0d z=%b want 14 2 0", q, r, z);
        else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL basic_idle_after got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_signs_boundaries();
        int ta[7] = '{-100, 100, -100, -4096, 4095, -4096, 5};
        int tb[7] = '{7, -7, -7, -1, 1, 63, -64};
        int tq[7] = '{-14, -14, 14, 4096, 4095, -65, 0};
        int tr[7] = '{-2, 2, -2, 0, 0, -1, 5};
        logic [12:0] q;
        logic [6:0]  r;
        logic        z;
        int          lat;
        bit          busy;
        for (int i = 0; i < 7; i++) begin
            run_op(13'(ta[i]), 7'(tb[i]), q, r, z, lat, busy);
            checks++;
            if ({q, r, z} !== {13'(tq[i]), 7'(tr[i]), 1'b0})
                $display("FAIL sign_bound_%0d got q=%h r=%h z=%b want q=%h r=%h z=0",
                         i, q, r, z, 13'(tq[i]), 7'(tr[i]));
            else passed++;
        end
    endtask

    task automatic test_div0();
        logic [12:0] q;
        logic [6:0]  r;
        logic        z;
        int          lat;
        bit          busy;
        run_op(13'd1234, 7'd0, q, r, z, lat, busy);
        checks++;
        if ({q, r, z} !== {13'h1FFF, 7'd0, 1'b1})
            $display("FAIL div0_result got q=%h r=%h z=%b want 1fff 0 1", q, r, z);
        else passed++;
        checks++;
        if (lat !== 14) $display("FAIL div0_latency got %0d want 14", lat);
        else passed++;
    endtask

    task automatic test_random();
        logic [12:0] a;
        logic [6:0]  b;
        logic [12:0] q;
        logic [6:0]  r;
        logic        z;
        logic [12:0] eq;
        logic [6:0]  er;
        logic        ez;
        int          lat;
        bit          busy;
        for (int i = 0; i < 24; i++) begin
            a = 13'($urandom);
            b = (i % 8 == 7) ? 7'd0 : 7'($urandom);
            model(a, b, eq, er, ez);
            run_op(a, b, q, r, z, lat, busy);
            checks++;
            if ({q, r, z, lat} !== {eq, er, ez, 32'd14})
                $display("FAIL random_%0d a=%h b=%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=14",
                         i, a, b, q, r, z, lat, eq, er, ez);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [12:0] eq;
        logic [6:0]  er;
        logic        ez;
        int          lat;
        bit          busy;
        bit          ok;
        model(13'd321, -7'sd9, eq, er, ez);
        issue(13'd321, -7'sd9);
        wait_valid(lat, busy);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din0 = 13'($urandom);
            din1 = 7'($urandom);
            in_valid = 1'b1;
            @(negedge ap_clk);
            if (!out_valid || in_ready || {dout, rem, div0} !== {eq, er, ez}) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1 || lat !== 14)
            $display("FAIL backpressure_hold got ok=%b lat=%0d dout=%h want ok=1 lat=14 dout=%h",
                     ok, lat, dout, eq);
        else passed++;
        in_valid = 1'b0;
        retire();
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL backpressure_retire got ov=%b ir=%b want 0 1", out_valid, in_ready);
        else passed++;
        @(negedge ap_clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL backpressure_no_capture got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_ce_stall();
        int tot;
        int en;
        issue(13'd1000, 7'd13);
        tot = 0;
        en = 0;
        while (!out_valid && tot < 60) begin
            ce = (tot >= 5 && tot < 8) ? 1'b0 : 1'b1;
            @(posedge ap_clk);
            tot++;
            if (ce) en++;
            @(negedge ap_clk);
        end
        ce = 1'b1;
        checks++;
        if (tot !== 17 || en !== 14)
            $display("FAIL ce_stall_latency got total=%0d enabled=%0d want 17 14", tot, en);
        else passed++;
        checks++;
        if ({dout, rem, div0} !== {13'd76, 7'd12, 1'b0})
            $display("FAIL ce_stall_result got q=%0d r=%0d z=%b want 76 12 0", dout, rem, div0);
        else passed++;
        retire();
    endtask

    task automatic test_reset_mid();
        logic [12:0] q;
        logic [6:0]  r;
        logic        z;
        int          lat;
        bit          busy;
        bit          seen;
        issue(13'd500, 7'd3);
        repeat (4) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, dout, rem} !== {1'b1, 1'b0, 13'd0, 7'd0})
            $display("FAIL reset_mid_state got ir=%b ov=%b dout=%h want 1 0 0", in_ready, out_valid, dout);
        else passed++;
        seen = 1'b0;
        repeat (20) begin
            @(negedge ap_clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL reset_mid_no_emit got %b want 0", seen);
        else passed++;
        run_op(13'd100, 7'd7, q, r, z, lat, busy);
        checks++;
        if ({q, r, z, lat} !== {13'd14, 7'd2, 1'b0, 32'd14})
            $display("FAIL reset_mid_next got q=%0d r=%0d z=%b lat=%0d want 14 2 0 14", q, r, z, lat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs_boundaries();
        test_div0();
        test_random();
        test_backpressure();
        test_ce_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/case_6_sdiv_13s_7s_13_seq.md
Name: case_6_sdiv_13s_7s_13_seq

Overview:
- Sequential signed divider that inverts the 13s×7s→13 multiply unit: dividend 13-bit signed, divisor 7-bit signed, quotient 13-bit and remainder 7-bit.
- Radix-2 restoring algorithm; one quotient bit per cycle.
- Valid/ready handshake on both sides so the HLS datapath can issue it and stall on it.
- Sits beside the multiplier core in the case_6 datapath.

Parameters:
- ID, 1, instance tag; no functional effect.
- din0_WIDTH, 13, dividend width (signed).
- din1_WIDTH, 7, divisor width (signed).
- dout_WIDTH, 13, quotient width.
- rem_WIDTH, 7, remainder width.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low, all registers hold.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit can accept operands.
- din0  in  13  signed dividend.
- din1  in  7  signed divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- dout  out  13  signed quotient.
- rem  out  7  signed remainder.
- div0  out  1  divide-by-zero flag, qualified by out_valid.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; dout=0; rem=0; div0=0; counter=0.
- Semantics follow C truncating division:
  - Quotient rounds toward zero.
  - Remainder takes the sign of the dividend.
  - dividend == dout*divisor + rem (mod 2^13).
- States:
  - IDLE: in_ready=1. On ce & in_valid, capture:
    - |din0| as 13-bit unsigned (|−4096| = 0x1000 fits).
    - |din1| as 7-bit unsigned.
    - Sign bits sq = din0[12]^din1[6] and sr = din0[12].
    - z = (din1 == 0).
    - Clear the 8-bit partial remainder, set counter=12, go to CALC.
  - CALC: 13 iterations, MSB first.
    - Shift the next dividend bit into the partial remainder.
    - If partial ≥ divisor magnitude: subtract and set the quotient bit to 1; otherwise the bit is 0.
    - When counter==0, go to FIX; otherwise decrement the counter.
  - FIX: apply signs.
    - dout = sq ? −q : q, truncated to 13 bits.
    - rem = sr ? −r : r.
    - If z: dout=13'h1FFF, rem=0, div0=1; otherwise div0=0.
    - Set out_valid=1 and go to DONE.
  - DONE: outputs held stable while out_valid=1. On ce & out_ready: out_valid=0, in_ready=1, go to IDLE.
- in_ready=1 only in IDLE, so a new operand cannot be accepted in the same cycle a result is retired. Minimum issue interval is 16 cycles.
- Latency:
  - Acceptance edge = E0.
  - out_valid becomes visible after E14, i.e. 14 enabled edges after acceptance.
  - Edges with ce=0 do not count.
- Overflow: −4096 / −1 wraps to dout=13'h1000 (−4096), rem=0, div0=0.
- Remainder range: |rem| ≤ 63, so it always fits in 7 bits signed.
- ce low in any state: full freeze, including handshake outputs. in_valid/out_ready are ignored while ce=0.
- ap_rst_n asserted mid-operation: abort immediately to the reset values. The in-flight result is discarded and never emitted.
- No X propagation: din0/din1 are sampled only on acceptance.

Decomposition:
- Shared package case_6_div_pkg:
  - Width constants DIV_N=13, DIV_D=7.
  - State enum {IDLE, CALC, FIX, DONE}.
  - Divide-by-zero quotient constant 13'h1FFF.
- One natural sub-module, case_6_sdiv_13s_7s_13_seq_step: combinational single restoring-step cell.
  - Inputs: partial remainder, incoming bit, divisor magnitude.
  - Outputs: next partial remainder, quotient bit.
  - The top level holds the FSM, counter and sign fix-up.

Test Plan:
- din0=100, din1=7, in_valid pulse with ce=1 → out_valid 14 edges later; dout=14, rem=2, div0=0; in_ready low throughout.
- Sign cases, each expected result independently:
  - −100/7 → dout=−14, rem=−2.
  - 100/−7 → dout=−14, rem=2.
  - −100/−7 → dout=14, rem=−2.
- Boundaries, each expected result independently:
  - −4096/−1 → dout=13'h1000, rem=0.
  - 4095/1 → dout=4095.
  - −4096/63 → dout=−65, rem=−1.
  - 5/−64 → dout=0, rem=5.
- din1=0, din0=1234 → dout=13'h1FFF, rem=0, div0=1 at the normal latency.
- Hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, in_valid ignored; then retire with out_ready=1 → IDLE next cycle.
- Toggle ce low for 3 cycles mid-CALC → latency grows by exactly 3 and the result is unchanged.
- Assert ap_rst_n=0 for 1 cycle at CALC iteration 5 → out_valid never pulses for that operand; in_ready=1 after release; the next operand 100/7 completes correctly.
